// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the conv channel scheduler.
package conv_sched_pkg;

  // Scheduler states; the encoding is also exposed on the debug port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    NEXT  = 3'd4,
    ERROR = 3'd5
  } state_t;

  // Error codes reported on err_code while in ERROR.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_COLS    = 2'b10;
  localparam logic [1:0] ERR_CREDIT  = 2'b11;

  // Output columns produced per kernel by a valid-only convolution.
  function automatic int cols_per_ch(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_channel_scheduler_if.sv
// Engine-side and tag-side signals of the conv channel scheduler.
//
// Handshake semantics: engine_start is a single-cycle command pulse.
// engine_col_valid and tag_valid are pure valid qualifiers with no ready:
// a column is transferred in every cycle its valid is high, and the sink
// can never stall it. Downstream back-pressure is handled upstream of the
// engine by credits, so the scheduler only starts a kernel once enough
// column-buffer slots are reserved. engine_done is a single-cycle pulse
// that may coincide with the last column's valid.
interface conv_channel_scheduler_if #(
  parameter int CH_W  = 3,
  parameter int COL_W = 5
);
  logic             engine_start;
  logic [CH_W-1:0]  engine_kernel_sel;
  logic             engine_col_valid;
  logic             engine_done;
  logic             tag_valid;
  logic [CH_W-1:0]  tag_channel;
  logic [COL_W-1:0] tag_col;

  // Scheduler side.
  modport master (
    output engine_start, engine_kernel_sel, tag_valid, tag_channel, tag_col,
    input  engine_col_valid, engine_done
  );

  // Engine and feature-map writer side.
  modport slave (
    input  engine_start, engine_kernel_sel, tag_valid, tag_channel, tag_col,
    output engine_col_valid, engine_done
  );
endinterface

// File: rtl/conv_credit_counter.sv
// Saturating credit counter: one reservation of RESERVE slots per kernel,
// one slot returned per credit pulse, with a return-overflow flag.
module conv_credit_counter #(
  parameter  int CREDIT_MAX = 48,
  parameter  int RESERVE    = 24,
  localparam int W          = $clog2(CREDIT_MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reserve,
  input  logic         ret,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W:0] RES_V = (W + 1)'(RESERVE);
  localparam logic [W:0] MAX_V = (W + 1)'(CREDIT_MAX);

  logic [W:0] sum;

  // A return arriving while the counter is already full is dropped and
  // reported; a return coinciding with a reservation always fits.
  assign overflow = ret && !reserve && (count == MAX_V[W-1:0]);

  // Net effect of this cycle's return and reservation, clamped to range.
  always_comb begin
    sum = {1'b0, count} + {{W{1'b0}}, ret};
    if (reserve) begin
      sum = (sum >= RES_V) ? (sum - RES_V) : '0;
    end
    if (sum > MAX_V) begin
      sum = MAX_V;
    end
  end

  // Credit register; reset restores the full downstream buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= MAX_V[W-1:0];
    end else begin
      count <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/conv_channel_scheduler.sv
// Runs the column-parallel conv engine once per output channel, tags each
// produced column with channel/column numbers, gates kernel starts on
// downstream credits and traps a hung or misbehaving engine.
module conv_channel_scheduler
  import conv_sched_pkg::*;
#(
  parameter  int NUM_CHANNELS   = 6,
  parameter  int IMAGE_SIZE     = 28,
  parameter  int KERNEL_SIZE    = 5,
  parameter  int CREDIT_MAX     = 48,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int CFG_W          = $clog2(NUM_CHANNELS + 1),
  localparam int CRED_W         = $clog2(CREDIT_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      layer_start,
  input  logic [CFG_W-1:0]          num_channels_cfg,
  input  logic                      abort,
  input  logic                      credit_return,
  conv_channel_scheduler_if.master  sif,
  output logic                      busy,
  output logic                      layer_done,
  output logic                      error,
  output logic [1:0]                err_code,
  output state_t                    dbg_state,
  output logic [CRED_W-1:0]         dbg_credits
);

  localparam int CH_W  = index_width(NUM_CHANNELS);
  localparam int COL_W = index_width(IMAGE_SIZE);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int COLS  = cols_per_ch(IMAGE_SIZE, KERNEL_SIZE);

  localparam logic [COL_W:0]  COLS_V   = (COL_W + 1)'(COLS);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CRED_W-1:0] COLS_C = CRED_W'(COLS);

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CH_W-1:0]  ch_last_q, ch_last_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             reserve;
  logic             overflow;
  logic [CRED_W-1:0] credits;
  logic [CH_W-1:0]  cfg_last;
  logic [COL_W:0]   cols_seen;
  logic             col_full;
  logic             last_ch;

  conv_credit_counter #(
    .CREDIT_MAX (CREDIT_MAX),
    .RESERVE    (COLS)
  ) u_credits (
    .clk      (clk),
    .rst      (rst),
    .reserve  (reserve),
    .ret      (credit_return),
    .count    (credits),
    .overflow (overflow)
  );

  // Last channel index for the requested count: 0 means one channel,
  // anything above NUM_CHANNELS is clamped.
  always_comb begin
    if (num_channels_cfg == '0) begin
      cfg_last = '0;
    end else if (int'(num_channels_cfg) > NUM_CHANNELS) begin
      cfg_last = CH_W'(NUM_CHANNELS - 1);
    end else begin
      cfg_last = CH_W'(num_channels_cfg - 1'b1);
    end
  end

  // Column bookkeeping helpers; cols_seen counts a same-cycle valid.
  assign cols_seen = {1'b0, col_cnt_q} + {{COL_W{1'b0}}, sif.engine_col_valid};
  assign col_full  = ({1'b0, col_cnt_q} == COLS_V);
  assign last_ch   = (ch_q == ch_last_q);

  // Next-state logic; credit overflow and then abort override the FSM.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    ch_last_d  = ch_last_q;
    col_cnt_d  = col_cnt_q;
    wd_d       = wd_q;
    err_code_d = err_code_q;
    reserve    = 1'b0;
    case (state_q)
      IDLE: begin
        if (layer_start) begin
          ch_last_d = cfg_last;
          ch_d      = '0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (credits >= COLS_C) begin
          state_d = START;
        end
      end
      START: begin
        reserve   = 1'b1;
        col_cnt_d = '0;
        wd_d      = '0;
        state_d   = RUN;
      end
      RUN: begin
        wd_d = wd_q + 1'b1;
        if (sif.engine_col_valid) begin
          col_cnt_d = col_cnt_q + 1'b1;
        end
        if (sif.engine_col_valid && col_full) begin
          state_d    = ERROR;
          err_code_d = ERR_COLS;
        end else if (sif.engine_done) begin
          if (cols_seen != COLS_V) begin
            state_d    = ERROR;
            err_code_d = ERR_COLS;
          end else begin
            state_d = NEXT;
          end
        end else if (wd_q == WD_LAST) begin
          state_d    = ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      NEXT: begin
        if (last_ch) begin
          state_d = IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = ARM;
        end
      end
      ERROR: begin
        if (layer_start) begin
          err_code_d = ERR_NONE;
          ch_last_d  = cfg_last;
          ch_d       = '0;
          state_d    = ARM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (overflow) begin
      state_d    = ERROR;
      err_code_d = ERR_CREDIT;
    end
    if (abort) begin
      state_d    = IDLE;
      err_code_d = ERR_NONE;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      ch_last_q  <= '0;
      col_cnt_q  <= '0;
      wd_q       <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      ch_last_q  <= ch_last_d;
      col_cnt_q  <= col_cnt_d;
      wd_q       <= wd_d;
      err_code_q <= err_code_d;
    end
  end

  // Outputs are decoded from registered state; only tag_valid and
  // layer_done look at same-cycle inputs.
  assign sif.engine_start      = (state_q == START);
  assign sif.engine_kernel_sel = ch_q;
  assign sif.tag_valid         = (state_q == RUN) && sif.engine_col_valid;
  assign sif.tag_channel       = ch_q;
  assign sif.tag_col           = col_cnt_q;

  assign busy        = (state_q != IDLE) && (state_q != ERROR);
  assign layer_done  = (state_q == NEXT) && last_ch && !abort && !overflow;
  assign error       = (state_q == ERROR);
  assign err_code    = err_code_q;
  assign dbg_state   = state_q;
  assign dbg_credits = credits;

endmodule

// File: tb/tb_conv_channel_scheduler.sv
// Directed bench for conv_channel_scheduler with a behavioural engine model
// and a tag/kernel-select scoreboard.
module tb_conv_channel_scheduler;
  import conv_sched_pkg::*;

  localparam int NUM_CHANNELS   = 6;
  localparam int IMAGE_SIZE     = 28;
  localparam int KERNEL_SIZE    = 5;
  localparam int CREDIT_MAX     = 48;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int CH_W   = 3;
  localparam int COL_W  = 5;
  localparam int CFG_W  = 3;
  localparam int CRED_W = 6;
  localparam int TAG_W  = CH_W + COL_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             layer_start = 1'b0;
  logic             abort = 1'b0;
  logic             credit_return = 1'b0;
  logic [CFG_W-1:0] num_channels_cfg = '0;
  logic             busy, layer_done, error;
  logic [1:0]       err_code;
  state_t           dbg_state;
  logic [CRED_W-1:0] dbg_credits;

  conv_channel_scheduler_if #(.CH_W(CH_W), .COL_W(COL_W)) sif ();

  conv_channel_scheduler #(
    .NUM_CHANNELS   (NUM_CHANNELS),
    .IMAGE_SIZE     (IMAGE_SIZE),
    .KERNEL_SIZE    (KERNEL_SIZE),
    .CREDIT_MAX     (CREDIT_MAX),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .layer_start      (layer_start),
    .num_channels_cfg (num_channels_cfg),
    .abort            (abort),
    .credit_return    (credit_return),
    .sif              (sif),
    .busy             (busy),
    .layer_done       (layer_done),
    .error            (error),
    .err_code         (err_code),
    .dbg_state        (dbg_state),
    .dbg_credits      (dbg_credits)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int tag_cnt = 0;
  int eng_mode = 0;  // 0: 24 cols + done, 1: 23 cols + done, 2: 24 cols, no done

  logic [TAG_W-1:0] exp_q[$];
  logic [CH_W-1:0]  ks_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_layer(input int cfg);
    num_channels_cfg = CFG_W'(cfg);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic return_credits(input int n);
    for (int i = 0; i < n; i++) begin
      credit_return = 1'b1;
      tick();
    end
    credit_return = 1'b0;
  endtask

  task automatic push_tags(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({CH_W'(ch), COL_W'(i)});
    end
  endtask

  // Returns the cycle number of the next engine_start pulse.
  task automatic wait_start(input string name, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sif.engine_start) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no engine_start within %0d cycles", name, budget);
    end
  endtask

  // which = 0 waits for layer_done, which = 1 for error.
  task automatic wait_sig(input string name, input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && layer_done) || (which == 1 && error)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: not seen within %0d cycles", name, budget);
    end
  endtask

  // ---------------- engine model ----------------
  initial begin : engine_model
    int n;
    sif.engine_col_valid = 1'b0;
    sif.engine_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && sif.engine_start) begin
        n = (eng_mode == 1) ? 23 : 24;
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          #1;
          if (rst) break;
          sif.engine_col_valid = 1'b1;
        end
        @(posedge clk);
        #1 sif.engine_col_valid = 1'b0;
        if (eng_mode != 2 && !rst) begin
          sif.engine_done = 1'b1;
          @(posedge clk);
          #1 sif.engine_done = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (sif.engine_start) begin
        start_cnt++;
        if (ks_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL kernel_sel: unexpected start, got %0d expected none", sif.engine_kernel_sel);
        end else begin
          check("kernel_sel", 32'(sif.engine_kernel_sel), 32'(ks_q.pop_front()));
        end
      end
      if (sif.tag_valid) begin
        tag_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tag: unexpected ch %0d col %0d, expected none", sif.tag_channel, sif.tag_col);
        end else begin
          check("tag", 32'({sif.tag_channel, sif.tag_col}), 32'(exp_q.pop_front()));
        end
      end
      if (layer_done) done_cnt++;
    end
  end

  initial begin : global_limit
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : main
    int t0, t1, r_cyc, base;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_credits", dbg_credits, 48);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_start", sif.engine_start, 0);
    check("rst_tag_valid", sif.tag_valid, 0);
    check("rst_layer_done", layer_done, 0);
    tick();
    rst = 1'b0;
    tick();

    // Three channels, no returns: stall in ARM after channel 1, then
    // 24 returns release channel 2 two cycles after the last return.
    eng_mode = 0;
    ks_q.push_back(0); ks_q.push_back(1); ks_q.push_back(2);
    push_tags(0, 24); push_tags(1, 24); push_tags(2, 24);
    pulse_layer(3);
    repeat (90) @(negedge clk);
    check("stall_state", dbg_state, ARM);
    check("stall_busy", busy, 1);
    check("stall_credits", dbg_credits, 0);
    check("stall_starts", start_cnt, 2);
    tick();
    return_credits(24);
    r_cyc = cyc - 1;
    wait_start("third_start", 10, t0);
    check("third_start_gap", t0 - r_cyc, 2);
    wait_sig("layer3_done", 0, 60, t1);
    repeat (3) @(negedge clk);
    check("layer3_done_cnt", done_cnt, 1);
    check("layer3_starts", start_cnt, 3);
    check("layer3_tags", tag_cnt, 72);
    check("layer3_queue", exp_q.size(), 0);
    check("layer3_credits", dbg_credits, 0);
    check("layer3_idle", dbg_state, IDLE);

    // Refill, then one return too many: overflow error, credits held.
    tick();
    return_credits(48);
    @(negedge clk);
    check("refill_credits", dbg_credits, 48);
    tick();
    return_credits(1);
    @(negedge clk);
    check("ovf_state", dbg_state, ERROR);
    check("ovf_code", err_code, 3);
    check("ovf_error", error, 1);
    check("ovf_busy", busy, 0);
    check("ovf_credits", dbg_credits, 48);
    tick();
    pulse_abort();
    @(negedge clk);
    check("ovf_abort_state", dbg_state, IDLE);
    check("ovf_abort_error", error, 0);
    check("ovf_abort_code", err_code, 0);

    // Short engine: 23 columns then done -> column-count error.
    eng_mode = 1;
    ks_q.push_back(0);
    push_tags(0, 23);
    tick();
    pulse_layer(1);
    wait_sig("short_error", 1, 60, t1);
    check("short_code", err_code, 2);
    check("short_busy", busy, 0);
    check("short_state", dbg_state, ERROR);
    check("short_credits", dbg_credits, 24);
    check("short_no_done", done_cnt, 1);
    // New layer straight out of ERROR clears the error and restarts ch 0.
    eng_mode = 0;
    ks_q.push_back(0);
    push_tags(0, 24);
    tick();
    pulse_layer(1);
    @(negedge clk);
    check("restart_error", error, 0);
    check("restart_code", err_code, 0);
    check("restart_state", dbg_state, ARM);
    wait_sig("restart_done", 0, 60, t1);
    @(negedge clk);
    check("restart_credits", dbg_credits, 0);
    check("restart_queue", exp_q.size(), 0);
    check("restart_done_cnt", done_cnt, 2);

    // Hung engine: start pulse in cycle t0, RUN holds wd 0..63 for 64
    // cycles, error first visible in cycle t0 + 65.
    tick();
    return_credits(48);
    eng_mode = 2;
    ks_q.push_back(0);
    push_tags(0, 24);
    pulse_layer(1);
    wait_start("hang_start", 10, t0);
    wait_sig("hang_error", 1, 120, t1);
    check("timeout_cycles", t1 - t0, 65);
    check("timeout_code", err_code, 1);
    check("timeout_credits", dbg_credits, 24);
    tick();
    pulse_abort();
    @(negedge clk);
    check("timeout_abort_state", dbg_state, IDLE);
    check("timeout_abort_error", error, 0);

    // Abort ten columns into channel 1.
    tick();
    return_credits(24);
    eng_mode = 0;
    ks_q.push_back(0); ks_q.push_back(1);
    push_tags(0, 24); push_tags(1, 10);
    pulse_layer(2);
    wait_start("abort_ch0", 10, t0);
    wait_start("abort_ch1", 60, t0);
    repeat (10) @(posedge clk);
    #1;
    pulse_abort();
    @(negedge clk);
    check("abort_state", dbg_state, IDLE);
    check("abort_busy", busy, 0);
    check("abort_credits", dbg_credits, 0);
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt, 2);
    check("abort_queue", exp_q.size(), 0);

    // Asynchronous reset in the middle of RUN.
    tick();
    return_credits(24);
    ks_q.push_back(0);
    push_tags(0, 4);
    pulse_layer(1);
    wait_start("rst_run_start", 10, t0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_state", dbg_state, IDLE);
    check("async_rst_busy", busy, 0);
    check("async_rst_credits", dbg_credits, 48);
    check("async_rst_tag_valid", sif.tag_valid, 0);
    check("async_rst_start", sif.engine_start, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (30) tick();
    check("async_rst_queue", exp_q.size(), 0);

    // Credit return in the START cycle, with cfg 0 meaning one channel.
    ks_q.push_back(0);
    push_tags(0, 24);
    base = done_cnt;
    num_channels_cfg = '0;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    tick();
    credit_return = 1'b1;
    @(negedge clk);
    check("coincident_start", sif.engine_start, 1);
    tick();
    credit_return = 1'b0;
    @(negedge clk);
    check("coincident_credits", dbg_credits, 25);
    wait_sig("cfg0_done", 0, 60, t1);
    repeat (8) @(negedge clk);
    check("cfg0_one_done", done_cnt - base, 1);
    check("cfg0_queue", exp_q.size(), 0);
    check("cfg0_credits", dbg_credits, 25);

    // Abort and layer_start together: abort wins.
    tick();
    layer_start = 1'b1;
    abort = 1'b1;
    tick();
    layer_start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_wins_state", dbg_state, IDLE);
    check("abort_wins_busy", busy, 0);

    repeat (4) @(negedge clk);
    check("total_starts", start_cnt, 10);
    check("ks_queue", ks_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
